// File: rtl/udi_issue_seq.sv
// UDI issue sequencer: issues one command at a time to a UDI responder through
// an IDLE/EXEC/MEM pipeline and queues each result in a first-word-fall-through FIFO.
module udi_issue_seq #(
  parameter int          RSP_DEPTH     = 4,
  parameter int          STALL_TIMEOUT = 16,
  parameter logic [5:0]  MAJ_OP        = 6'd28
) (
  input  logic        UDI_gclk,
  input  logic        UDI_greset,
  // command side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_funct,
  input  logic [4:0]  cmd_rd,
  input  logic [31:0] cmd_rs,
  input  logic [31:0] cmd_rt,
  input  logic        cmd_kill,
  input  logic        cfg_endianb,
  input  logic        cfg_kd_mode,
  // UDI responder side
  output logic [31:0] UDI_ir_e,
  output logic [31:0] UDI_rs_e,
  output logic [31:0] UDI_rt_e,
  output logic        UDI_irvalid_e,
  output logic        UDI_start_e,
  output logic        UDI_run_m,
  output logic        UDI_kill_m,
  output logic        UDI_endianb_e,
  output logic        UDI_kd_mode_e,
  input  logic [31:0] UDI_rd_m,
  input  logic [4:0]  UDI_wrreg_e,
  input  logic        UDI_ri_e,
  input  logic        UDI_stall_m,
  input  logic        UDI_present,
  // response side
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_wrreg,
  output logic [1:0]  rsp_status,
  output logic        busy
);

  localparam int PTR_W   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W   = $clog2(RSP_DEPTH + 1);
  localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);
  localparam int ENT_W   = 32 + 5 + 2;

  localparam logic [CNT_W-1:0]   FIFO_FULL  = CNT_W'(RSP_DEPTH);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_RI     = 2'b01;
  localparam logic [1:0] ST_KILLED = 2'b10;
  localparam logic [1:0] ST_TMO    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MEM  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [31:0]        ir_reg, rs_reg, rt_reg;
  logic [4:0]         wrreg_reg;

  logic [ENT_W-1:0]   fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;

  logic               cmd_fire;
  logic               push, pop;
  logic [ENT_W-1:0]   push_entry;
  logic               kill_m;
  logic [ENT_W-1:0]   head_entry;

  // Ready is gated by reset directly so it stays low for the whole reset window.
  assign cmd_ready = !UDI_greset && (state_reg == IDLE) &&
                     (count_reg < FIFO_FULL) && UDI_present;
  assign cmd_fire  = cmd_valid && cmd_ready;

  assign busy          = (state_reg != IDLE);
  assign UDI_irvalid_e = (state_reg == EXEC);
  assign UDI_start_e   = (state_reg == EXEC);
  assign UDI_run_m     = (state_reg == MEM);
  assign UDI_kill_m    = kill_m;
  assign UDI_endianb_e = cfg_endianb;
  assign UDI_kd_mode_e = cfg_kd_mode;
  assign UDI_ir_e      = ir_reg;
  assign UDI_rs_e      = rs_reg;
  assign UDI_rt_e      = rt_reg;

  always_ff @(posedge UDI_gclk or posedge UDI_greset) begin
    if (UDI_greset) begin
      state_reg     <= IDLE;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  // Kill outranks completion, and completion outranks the stall timeout.
  always_comb begin
    state_next     = state_reg;
    stall_cnt_next = stall_cnt_reg;
    push           = 1'b0;
    push_entry     = '0;
    kill_m         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_fire) state_next = EXEC;
      end
      EXEC: begin
        stall_cnt_next = '0;
        if (UDI_ri_e) begin
          push       = 1'b1;
          push_entry = {32'd0, UDI_wrreg_e, ST_RI};
          state_next = IDLE;
        end else begin
          state_next = MEM;
        end
      end
      MEM: begin
        if (cmd_kill) begin
          kill_m     = 1'b1;
          push       = 1'b1;
          push_entry = {32'd0, wrreg_reg, ST_KILLED};
          state_next = IDLE;
        end else if (!UDI_stall_m) begin
          push       = 1'b1;
          push_entry = {UDI_rd_m, wrreg_reg, ST_OK};
          state_next = IDLE;
        end else if (stall_cnt_reg >= STALL_LAST) begin
          kill_m         = 1'b1;
          push           = 1'b1;
          push_entry     = {32'd0, wrreg_reg, ST_TMO};
          stall_cnt_next = stall_cnt_reg + 1'b1;
          state_next     = IDLE;
        end else begin
          stall_cnt_next = stall_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge UDI_gclk or posedge UDI_greset) begin
    if (UDI_greset) begin
      ir_reg    <= '0;
      rs_reg    <= '0;
      rt_reg    <= '0;
      wrreg_reg <= '0;
    end else begin
      if (cmd_fire) begin
        ir_reg <= {MAJ_OP, 5'd0, 5'd0, cmd_rd, 5'd0, cmd_funct};
        rs_reg <= cmd_rs;
        rt_reg <= cmd_rt;
      end
      if (state_reg == EXEC) wrreg_reg <= UDI_wrreg_e;
    end
  end

  // Response FIFO: small distributed storage so the head is visible combinationally.
  assign rsp_valid = (count_reg != '0);
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge UDI_gclk) begin
    if (push) fifo_mem[wr_ptr_reg] <= push_entry;
  end

  always_ff @(posedge UDI_gclk or posedge UDI_greset) begin
    if (UDI_greset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_entry = fifo_mem[rd_ptr_reg];
  assign rsp_data   = head_entry[ENT_W-1:7];
  assign rsp_wrreg  = head_entry[6:2];
  assign rsp_status = head_entry[1:0];

endmodule

// File: tb/tb_udi_issue_seq.sv
// Bench for udi_issue_seq: scripted scenarios plus randomized instructions checked
// against a queue-based response model and a per-cycle expected control timeline.
module tb_udi_issue_seq;

  localparam int         RSP_DEPTH     = 4;
  localparam int         STALL_TIMEOUT = 16;
  localparam logic [5:0] MAJ_OP        = 6'd28;

  logic        clk = 1'b0;
  logic        UDI_greset;
  logic        cmd_valid, cmd_ready;
  logic [5:0]  cmd_funct;
  logic [4:0]  cmd_rd;
  logic [31:0] cmd_rs, cmd_rt;
  logic        cmd_kill, cfg_endianb, cfg_kd_mode;
  logic [31:0] UDI_ir_e, UDI_rs_e, UDI_rt_e;
  logic        UDI_irvalid_e, UDI_start_e, UDI_run_m, UDI_kill_m;
  logic        UDI_endianb_e, UDI_kd_mode_e;
  logic [31:0] UDI_rd_m;
  logic [4:0]  UDI_wrreg_e;
  logic        UDI_ri_e, UDI_stall_m, UDI_present;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_wrreg;
  logic [1:0]  rsp_status;
  logic        busy;

  always #5 clk = ~clk;

  udi_issue_seq #(.RSP_DEPTH(RSP_DEPTH), .STALL_TIMEOUT(STALL_TIMEOUT), .MAJ_OP(MAJ_OP)) dut (
    .UDI_gclk(clk), .UDI_greset(UDI_greset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct(cmd_funct), .cmd_rd(cmd_rd),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_kill(cmd_kill),
    .cfg_endianb(cfg_endianb), .cfg_kd_mode(cfg_kd_mode),
    .UDI_ir_e(UDI_ir_e), .UDI_rs_e(UDI_rs_e), .UDI_rt_e(UDI_rt_e),
    .UDI_irvalid_e(UDI_irvalid_e), .UDI_start_e(UDI_start_e), .UDI_run_m(UDI_run_m),
    .UDI_kill_m(UDI_kill_m), .UDI_endianb_e(UDI_endianb_e), .UDI_kd_mode_e(UDI_kd_mode_e),
    .UDI_rd_m(UDI_rd_m), .UDI_wrreg_e(UDI_wrreg_e), .UDI_ri_e(UDI_ri_e),
    .UDI_stall_m(UDI_stall_m), .UDI_present(UDI_present),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_wrreg(rsp_wrreg), .rsp_status(rsp_status), .busy(busy)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  wrreg;
    logic [1:0]  status;
  } rsp_t;

  rsp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and play the responder; expected controls per cycle and the
  // expected response come from the instruction's outcome rules.
  task automatic run_instr(input logic [5:0] funct, input logic [4:0] rd,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input logic [4:0] wrreg, input logic ri,
                           input int stall_cycles, input int kill_at, input int reset_at,
                           input logic [31:0] rdval, input string tag);
    logic [31:0] exp_ir;
    logic        stall, kill, exp_kill;
    int          k;
    bit          done;
    rsp_t        r;
    exp_ir    = {MAJ_OP, 10'd0, rd, 5'd0, funct};
    cmd_valid = 1'b1; cmd_funct = funct; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
    #1;
    k = 0;
    while (!cmd_ready && k < 200) begin
      step(); #1; k++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s accept: cmd_ready=%b required 1", tag, cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    step();
    cmd_valid = 1'b0; UDI_wrreg_e = wrreg; UDI_ri_e = ri;
    #1;
    total++;
    if ({UDI_irvalid_e, UDI_start_e, UDI_run_m, UDI_kill_m, busy, cmd_ready} !== 6'b110010) begin
      bad++;
      $display("FAIL %s exec_ctl: got %b required 110010", tag,
               {UDI_irvalid_e, UDI_start_e, UDI_run_m, UDI_kill_m, busy, cmd_ready});
    end
    total++;
    if ({UDI_ir_e, UDI_rs_e, UDI_rt_e} !== {exp_ir, rs, rt}) begin
      bad++;
      $display("FAIL %s exec_ops: got %h %h %h required %h %h %h", tag,
               UDI_ir_e, UDI_rs_e, UDI_rt_e, exp_ir, rs, rt);
    end
    step();
    UDI_ri_e = 1'b0;
    done = ri;
    if (ri) begin
      r = '{32'd0, wrreg, 2'b01};
      exp_q.push_back(r);
    end
    k = 1;
    while (!done && k <= STALL_TIMEOUT + 4) begin
      stall = (k <= stall_cycles);
      kill  = (k == kill_at);
      UDI_stall_m = stall; cmd_kill = kill;
      UDI_rd_m = stall ? $urandom : rdval;
      if (k == reset_at) begin
        UDI_greset = 1'b1;
        #1;
        total++;
        if ({rsp_valid, busy, UDI_run_m, UDI_kill_m, UDI_irvalid_e, cmd_ready} !== 6'b0 ||
            UDI_ir_e !== 32'd0) begin
          bad++;
          $display("FAIL %s reset_mid: ctl=%b ir=%h required 000000 ir=0", tag,
                   {rsp_valid, busy, UDI_run_m, UDI_kill_m, UDI_irvalid_e, cmd_ready}, UDI_ir_e);
        end
        UDI_stall_m = 1'b0; cmd_kill = 1'b0;
        step();
        UDI_greset = 1'b0;
        exp_q.delete();
        return;
      end
      #1;
      exp_kill = kill || (stall && k == STALL_TIMEOUT);
      total++;
      if ({UDI_irvalid_e, UDI_start_e, UDI_run_m, UDI_kill_m, busy} !== {3'b001, exp_kill, 1'b1}) begin
        bad++;
        $display("FAIL %s mem_ctl k=%0d: got %b required %b", tag, k,
                 {UDI_irvalid_e, UDI_start_e, UDI_run_m, UDI_kill_m, busy}, {3'b001, exp_kill, 1'b1});
      end
      if (kill) begin
        r = '{32'd0, wrreg, 2'b10}; exp_q.push_back(r); done = 1;
      end else if (!stall) begin
        r = '{rdval, wrreg, 2'b00}; exp_q.push_back(r); done = 1;
      end else if (k == STALL_TIMEOUT) begin
        r = '{32'd0, wrreg, 2'b11}; exp_q.push_back(r); done = 1;
      end
      step();
      k++;
    end
    UDI_stall_m = 1'b0; cmd_kill = 1'b0;
    #1;
    total++;
    if ({UDI_irvalid_e, UDI_start_e, UDI_run_m, UDI_kill_m, busy, rsp_valid} !== 6'b000001 ||
        UDI_ir_e !== exp_ir) begin
      bad++;
      $display("FAIL %s post_idle: ctl=%b ir=%h required 000001 ir=%h", tag,
               {UDI_irvalid_e, UDI_start_e, UDI_run_m, UDI_kill_m, busy, rsp_valid}, UDI_ir_e, exp_ir);
    end
    $display("instr %s funct=%h rd=%0d wrreg=%0d ri=%0d stall=%0d kill_at=%0d", tag, funct, rd,
             wrreg, ri, stall_cycles, kill_at);
  endtask

  task automatic drain(input string tag);
    rsp_t r;
    rsp_ready = 1'b1;
    #1;
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      total++;
      if ({rsp_valid, rsp_data, rsp_wrreg, rsp_status} !== {1'b1, r.data, r.wrreg, r.status}) begin
        bad++;
        $display("FAIL %s rsp: got v=%b d=%h w=%0d s=%b required v=1 d=%h w=%0d s=%b", tag,
                 rsp_valid, rsp_data, rsp_wrreg, rsp_status, r.data, r.wrreg, r.status);
      end
      $display("rsp %s data=%h wrreg=%0d status=%b", tag, rsp_data, rsp_wrreg, rsp_status);
      step();
      #1;
    end
    rsp_ready = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s empty: rsp_valid=%b required 0", tag, rsp_valid);
    end
  endtask

  task automatic test_reset();
    UDI_greset = 1'b1;
    cmd_valid = 0; cmd_funct = 0; cmd_rd = 0; cmd_rs = 0; cmd_rt = 0; cmd_kill = 0;
    cfg_endianb = 0; cfg_kd_mode = 0; UDI_rd_m = 0; UDI_wrreg_e = 0; UDI_ri_e = 0;
    UDI_stall_m = 0; UDI_present = 1; rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cmd_ready, rsp_valid, busy, UDI_irvalid_e, UDI_start_e, UDI_run_m, UDI_kill_m} !== 7'b0 ||
        {UDI_ir_e, UDI_rs_e, UDI_rt_e} !== 96'd0) begin
      bad++;
      $display("FAIL reset_state: ctl=%b ir=%h rs=%h rt=%h required all 0",
               {cmd_ready, rsp_valid, busy, UDI_irvalid_e, UDI_start_e, UDI_run_m, UDI_kill_m},
               UDI_ir_e, UDI_rs_e, UDI_rt_e);
    end
    UDI_greset = 1'b0;
    step();
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready);
    end
    $display("reset checked");
  endtask

  task automatic test_static();
    UDI_present = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL not_present: cmd_ready=%b required 0", cmd_ready);
    end
    UDI_present = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_endianb = i[0]; cfg_kd_mode = i[1];
      #1;
      total++;
      if ({UDI_endianb_e, UDI_kd_mode_e} !== {i[0], i[1]}) begin
        bad++;
        $display("FAIL cfg_pass: got %b required %b", {UDI_endianb_e, UDI_kd_mode_e}, {i[0], i[1]});
      end
    end
    $display("static outputs checked");
  endtask

  task automatic test_sum();
    run_instr(6'd16, 5'd5, 32'h0003_0000, 32'h0004_0000, 5'd5, 1'b0, 2, 0, 0, 32'd25, "sum");
    drain("sum");
  endtask

  task automatic test_ri();
    run_instr(6'h1F, 5'd3, 32'h1234, 32'h5678, 5'd9, 1'b1, 0, 0, 0, 32'hdead, "ri");
    drain("ri");
  endtask

  task automatic test_kill();
    run_instr(6'd17, 5'd7, 32'h1, 32'h2, 5'd7, 1'b0, 100, 2, 0, 32'hbeef, "kill");
    drain("kill");
  endtask

  task automatic test_timeout();
    run_instr(6'd18, 5'd8, 32'h3, 32'h4, 5'd12, 1'b0, 100, 0, 0, 32'hcafe, "timeout");
    drain("timeout");
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < RSP_DEPTH; i++)
      run_instr(6'(i + 1), 5'(i), $urandom, $urandom, 5'(i + 20), 1'b0, i, 0, 0, $urandom, "bp");
    cmd_valid = 1'b1; cmd_funct = 6'd40; cmd_rd = 5'd1; cmd_rs = 32'h9; cmd_rt = 32'ha;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({cmd_ready, busy} !== 2'b00) begin
        bad++;
        $display("FAIL bp_full: cmd_ready,busy=%b required 00", {cmd_ready, busy});
      end
    end
    cmd_valid = 1'b0;
    drain("bp");
    run_instr(6'd40, 5'd1, 32'h9, 32'ha, 5'd30, 1'b0, 0, 0, 0, 32'h5555_aaaa, "bp5");
    drain("bp5");
  endtask

  task automatic test_reset_mid();
    run_instr(6'd19, 5'd4, 32'h7, 32'h8, 5'd4, 1'b0, 100, 0, 3, 32'h0, "rstmid");
    total++;
    if ({rsp_valid, busy, UDI_kill_m} !== 3'b000) begin
      bad++;
      $display("FAIL rstmid_after: rsp_valid,busy,kill_m=%b required 000", {rsp_valid, busy, UDI_kill_m});
    end
    run_instr(6'd20, 5'd6, 32'h11, 32'h22, 5'd6, 1'b0, 1, 0, 0, 32'h33, "fresh");
    drain("fresh");
  endtask

  task automatic test_random();
    logic [5:0] f;
    logic       ri;
    int         st, ka;
    for (int n = 0; n < 40; n++) begin
      f  = 6'($urandom);
      ri = ($urandom_range(0, 5) == 0);
      st = $urandom_range(0, 20);
      ka = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 20) : 0;
      cfg_endianb = 1'($urandom); cfg_kd_mode = 1'($urandom);
      run_instr(f, 5'($urandom), $urandom, $urandom, 5'($urandom), ri, st, ka, 0, $urandom, "rand");
      total++;
      if ({UDI_endianb_e, UDI_kd_mode_e} !== {cfg_endianb, cfg_kd_mode}) begin
        bad++;
        $display("FAIL rand_cfg: got %b required %b", {UDI_endianb_e, UDI_kd_mode_e},
                 {cfg_endianb, cfg_kd_mode});
      end
      if (exp_q.size() >= RSP_DEPTH || $urandom_range(0, 3) == 0) drain("rand");
    end
    drain("rand");
  endtask

  initial begin
    test_reset();
    test_static();
    test_sum();
    test_ri();
    test_kill();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/udi_issue_seq.md
UDI_ISSUE_SEQ -- requirements
Module: udi_issue_seq

Interface
REQ-001 SHALL have parameter RSP_DEPTH, default 4, meaning the number of response FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter STALL_TIMEOUT, default 16, meaning the maximum number of M-stage cycles with UDI_stall_m high before abort.
REQ-003 SHALL have parameter MAJ_OP, default 6'd28, meaning the Spec2 major opcode placed in ir[31:26].
REQ-004 Clock and reset: one clock, UDI_gclk; reset UDI_greset is asynchronous and active-high.
REQ-005 UDI_gclk  in  1  clock.
REQ-006 UDI_greset  in  1  asynchronous active-high reset.
REQ-007 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; a transfer occurs when both are high on a rising edge.
REQ-008 cmd_funct  in  6, cmd_rd  in  5, cmd_rs  in  32, cmd_rt  in  32  command fields.
REQ-009 cmd_kill  in  1  request to abort the instruction currently in M.
REQ-010 cfg_endianb, cfg_kd_mode  in  1 each  static mode bits.
REQ-011 UDI_ir_e, UDI_rs_e, UDI_rt_e  out  32 each  instruction and operands to the UDI responder.
REQ-012 UDI_irvalid_e, UDI_start_e, UDI_run_m, UDI_kill_m, UDI_endianb_e, UDI_kd_mode_e  out  1 each  pipeline controls.
REQ-013 UDI_rd_m  in  32, UDI_wrreg_e  in  5, UDI_ri_e  in  1, UDI_stall_m  in  1, UDI_present  in  1  responder returns.
REQ-014 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-015 rsp_data  out  32, rsp_wrreg  out  5, rsp_status  out  2  response fields: 00 ok, 01 reserved-instruction, 10 killed, 11 timeout.
REQ-016 busy  out  1  high when the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, EXEC and MEM, with one instruction in flight at most.
REQ-018 cmd_ready SHALL be high only in IDLE, when FIFO occupancy < RSP_DEPTH and UDI_present=1.
REQ-019 On a command transfer, the block SHALL register ir={MAJ_OP,5'd0,5'd0,cmd_rd,5'd0,cmd_funct}, rs=cmd_rs and rt=cmd_rt, and enter EXEC on the next cycle.
REQ-020 EXEC SHALL last exactly one cycle with UDI_irvalid_e=1 and UDI_start_e=1; both SHALL be 0 in all other states.
REQ-021 In EXEC the block SHALL sample UDI_wrreg_e and UDI_ri_e.
REQ-022 If UDI_ri_e=1 in EXEC, the block SHALL push {data=0, wrreg, status=01} and return to IDLE without entering MEM.
REQ-023 If UDI_ri_e=0 in EXEC, the block SHALL enter MEM.
REQ-024 UDI_run_m SHALL be 1 only in MEM.
REQ-025 In MEM, a cmd_kill=1 SHALL drive UDI_kill_m=1 combinationally that cycle, push {0, wrreg, 10} and return to IDLE; kill has priority over completion.
REQ-026 In MEM, with no kill and UDI_stall_m=0, the block SHALL capture UDI_rd_m, push {rd_m, wrreg, 00} and return to IDLE.
REQ-027 In MEM, with UDI_stall_m=1, the stall counter SHALL increment.
REQ-028 On the MEM cycle where the stall count reaches STALL_TIMEOUT, the block SHALL assert UDI_kill_m=1, push {0, wrreg, 11} and return to IDLE.
REQ-029 The stall counter SHALL clear on entry to MEM and be wide enough for STALL_TIMEOUT without wrap.
REQ-030 UDI_kill_m SHALL be 0 outside MEM.
REQ-031 UDI_ir_e, UDI_rs_e and UDI_rt_e SHALL hold their last values outside EXEC.
REQ-032 UDI_endianb_e and UDI_kd_mode_e SHALL equal cfg_endianb and cfg_kd_mode combinationally.
REQ-033 Minimum issue interval SHALL be 3 cycles per non-stalled instruction (IDLE, EXEC, MEM).
REQ-034 The response FIFO SHALL be first-word-fall-through, with rsp_valid = not empty and rsp_* showing the head entry.
REQ-035 A simultaneous push and pop SHALL leave occupancy unchanged; the pointers SHALL wrap modulo RSP_DEPTH.
REQ-036 The FIFO cannot overflow, because acceptance requires occupancy < RSP_DEPTH with one instruction in flight; a pop on empty SHALL be ignored.
REQ-037 A command arriving while not in IDLE SHALL stall on cmd_ready=0; the block SHALL drop no commands.

Reset
REQ-038 While UDI_greset=1: state=IDLE; FIFO empty; stall counter=0; ir/rs/rt registers=0.
REQ-039 While UDI_greset=1: cmd_ready=0, rsp_valid=0, busy=0, and UDI_irvalid_e, UDI_start_e, UDI_run_m and UDI_kill_m all 0.
REQ-040 Reset during EXEC or MEM SHALL discard the in-flight instruction with no response pushed and no kill pulse.
REQ-041 cmd_ready SHALL become valid on the first clock edge after reset deassertion.

Verification
REQ-042 Pipelined sum: funct=16, rd=5, rs=0x00030000, rt=0x00040000, responder stalls 2 MEM cycles then rd_m=25 -> one response {25, 5, 00}; irvalid_e high exactly one cycle.
REQ-043 Reserved instruction: funct=0x1F, responder raises ri_e -> response {0, wrreg, 01}; run_m never asserted.
REQ-044 Kill: funct=17, stall_m held high, cmd_kill pulsed on 2nd MEM cycle -> kill_m high that cycle only; response status 10; back to IDLE next cycle.
REQ-045 Timeout: stall_m stuck high, STALL_TIMEOUT=16 -> kill_m on 16th MEM cycle; response status 11.
REQ-046 Back-pressure: rsp_ready=0, issue 5 commands with RSP_DEPTH=4 -> 4 accepted, cmd_ready=0 afterward; raise rsp_ready -> 5th accepted; all 5 responses in order.
REQ-047 Reset mid-MEM: assert UDI_greset during a stall -> rsp_valid=0, busy=0; a fresh command afterward completes normally.
